// File: rtl/jellyvl_etherneco_syncgpio_pkg.sv
// Shared types and constants for the EtherNeco sync-GPIO controller.
package jellyvl_etherneco_syncgpio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [7:0] DEFAULT_FRAME_TYPE = 8'h20;

endpackage

// File: rtl/jellyvl_etherneco_syncgpio_watchdog.sv
// Loss-of-sync watchdog: counts cycles since the last clear, saturating at
// TIMEOUT_CYCLES, and flags timeout once the limit is reached.
module jellyvl_etherneco_syncgpio_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic reset,
  input  logic clk,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end
    timeout_d = (cnt_d == LIMIT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;

endmodule

// File: rtl/jellyvl_etherneco_syncgpio_controller.sv
// Sync-GPIO slave sequencer: freezes the tx image during a frame, commits rx
// data and swaps in the user shadow image on each good frame.
module jellyvl_etherneco_syncgpio_controller
  import jellyvl_etherneco_syncgpio_pkg::*;
#(
  parameter int unsigned GLOBAL_BYTES   = 4,
  parameter int unsigned LOCAL_BYTES    = 4,
  parameter logic [7:0]  FRAME_TYPE     = DEFAULT_FRAME_TYPE,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                      reset,
  input  logic                      clk,
  input  logic                      rx_start,
  input  logic                      rx_end,
  input  logic                      rx_error,
  input  logic [7:0]                rx_type,
  input  logic [GLOBAL_BYTES*8-1:0] global_rx_data,
  input  logic [LOCAL_BYTES*8-1:0]  local_rx_data,
  output logic [GLOBAL_BYTES*8-1:0] global_tx_mask,
  output logic [GLOBAL_BYTES*8-1:0] global_tx_data,
  output logic [LOCAL_BYTES*8-1:0]  local_tx_mask,
  output logic [LOCAL_BYTES*8-1:0]  local_tx_data,
  input  logic [GLOBAL_BYTES*8-1:0] s_global_mask,
  input  logic [GLOBAL_BYTES*8-1:0] s_global_data,
  input  logic [LOCAL_BYTES*8-1:0]  s_local_mask,
  input  logic [LOCAL_BYTES*8-1:0]  s_local_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic [GLOBAL_BYTES*8-1:0] m_global_data,
  output logic [LOCAL_BYTES*8-1:0]  m_local_data,
  output logic                      m_valid,
  output logic                      busy,
  output logic                      timeout,
  output logic [15:0]               frame_count,
  output logic [15:0]               error_count
);

  localparam int unsigned GW = GLOBAL_BYTES * 8;
  localparam int unsigned LW = LOCAL_BYTES * 8;

  state_t          state_q, state_d;
  logic [GW-1:0]   act_gmask_q, act_gmask_d, act_gdata_q, act_gdata_d;
  logic [LW-1:0]   act_lmask_q, act_lmask_d, act_ldata_q, act_ldata_d;
  logic [GW-1:0]   sh_gmask_q, sh_gmask_d, sh_gdata_q, sh_gdata_d;
  logic [LW-1:0]   sh_lmask_q, sh_lmask_d, sh_ldata_q, sh_ldata_d;
  logic            pending_q, pending_d;
  logic [GW-1:0]   m_gdata_q, m_gdata_d;
  logic [LW-1:0]   m_ldata_q, m_ldata_d;
  logic            m_valid_q, m_valid_d;
  logic            busy_q, busy_d;
  logic            s_ready_q, s_ready_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic [15:0]     err_cnt_q, err_cnt_d;
  logic            err_inc;

  always_comb begin
    state_d     = state_q;
    act_gmask_d = act_gmask_q;
    act_gdata_d = act_gdata_q;
    act_lmask_d = act_lmask_q;
    act_ldata_d = act_ldata_q;
    sh_gmask_d  = sh_gmask_q;
    sh_gdata_d  = sh_gdata_q;
    sh_lmask_d  = sh_lmask_q;
    sh_ldata_d  = sh_ldata_q;
    pending_d   = pending_q;
    m_gdata_d   = m_gdata_q;
    m_ldata_d   = m_ldata_q;
    m_valid_d   = 1'b0;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    err_inc     = 1'b0;

    // s_ready is low in COMMIT, so a load never races the swap below
    if (s_valid && s_ready_q) begin
      sh_gmask_d = s_global_mask;
      sh_gdata_d = s_global_data;
      sh_lmask_d = s_local_mask;
      sh_ldata_d = s_local_data;
      pending_d  = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (rx_start && (rx_type == FRAME_TYPE)) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (rx_error) begin
          state_d = IDLE;
          err_inc = 1'b1;
        end else if (rx_end) begin
          state_d = COMMIT;
        end else if (rx_start) begin
          err_inc = 1'b1;
        end
      end
      COMMIT: begin
        m_gdata_d   = global_rx_data;
        m_ldata_d   = local_rx_data;
        m_valid_d   = 1'b1;
        frame_cnt_d = frame_cnt_q + 16'd1;
        if (pending_q) begin
          act_gmask_d = sh_gmask_q;
          act_gdata_d = sh_gdata_q;
          act_lmask_d = sh_lmask_q;
          act_ldata_d = sh_ldata_q;
          pending_d   = 1'b0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (err_inc && (err_cnt_q != 16'hffff)) err_cnt_d = err_cnt_q + 16'd1;

    busy_d    = (state_d == ACTIVE);
    s_ready_d = (state_d != COMMIT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      act_gmask_q <= '0;
      act_gdata_q <= '0;
      act_lmask_q <= '0;
      act_ldata_q <= '0;
      sh_gmask_q  <= '0;
      sh_gdata_q  <= '0;
      sh_lmask_q  <= '0;
      sh_ldata_q  <= '0;
      pending_q   <= 1'b0;
      m_gdata_q   <= '0;
      m_ldata_q   <= '0;
      m_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
      s_ready_q   <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      act_gmask_q <= act_gmask_d;
      act_gdata_q <= act_gdata_d;
      act_lmask_q <= act_lmask_d;
      act_ldata_q <= act_ldata_d;
      sh_gmask_q  <= sh_gmask_d;
      sh_gdata_q  <= sh_gdata_d;
      sh_lmask_q  <= sh_lmask_d;
      sh_ldata_q  <= sh_ldata_d;
      pending_q   <= pending_d;
      m_gdata_q   <= m_gdata_d;
      m_ldata_q   <= m_ldata_d;
      m_valid_q   <= m_valid_d;
      busy_q      <= busy_d;
      s_ready_q   <= s_ready_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  jellyvl_etherneco_syncgpio_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .reset  (reset),
    .clk    (clk),
    .clear  (state_q == COMMIT),
    .enable (1'b1),
    .timeout(timeout)
  );

  assign global_tx_mask = act_gmask_q;
  assign global_tx_data = act_gdata_q;
  assign local_tx_mask  = act_lmask_q;
  assign local_tx_data  = act_ldata_q;
  assign m_global_data  = m_gdata_q;
  assign m_local_data   = m_ldata_q;
  assign m_valid        = m_valid_q;
  assign busy           = busy_q;
  assign s_ready        = s_ready_q;
  assign frame_count    = frame_cnt_q;
  assign error_count    = err_cnt_q;

endmodule

// File: tb/tb_jellyvl_etherneco_syncgpio_controller.sv
// Directed table-driven bench for the sync-GPIO controller.
module tb_jellyvl_etherneco_syncgpio_controller;

  logic        reset, clk;
  logic        rx_start, rx_end, rx_error;
  logic [7:0]  rx_type;
  logic [31:0] global_rx_data, local_rx_data;
  logic [31:0] global_tx_mask, global_tx_data, local_tx_mask, local_tx_data;
  logic [31:0] s_global_mask, s_global_data, s_local_mask, s_local_data;
  logic        s_valid, s_ready;
  logic [31:0] m_global_data, m_local_data;
  logic        m_valid, busy, timeout;
  logic [15:0] frame_count, error_count;

  int tests = 0;
  int fails = 0;

  jellyvl_etherneco_syncgpio_controller #(
    .GLOBAL_BYTES(4), .LOCAL_BYTES(4), .FRAME_TYPE(8'h20), .TIMEOUT_CYCLES(100)
  ) dut (
    .reset(reset), .clk(clk),
    .rx_start(rx_start), .rx_end(rx_end), .rx_error(rx_error), .rx_type(rx_type),
    .global_rx_data(global_rx_data), .local_rx_data(local_rx_data),
    .global_tx_mask(global_tx_mask), .global_tx_data(global_tx_data),
    .local_tx_mask(local_tx_mask), .local_tx_data(local_tx_data),
    .s_global_mask(s_global_mask), .s_global_data(s_global_data),
    .s_local_mask(s_local_mask), .s_local_data(s_local_data),
    .s_valid(s_valid), .s_ready(s_ready),
    .m_global_data(m_global_data), .m_local_data(m_local_data),
    .m_valid(m_valid), .busy(busy), .timeout(timeout),
    .frame_count(frame_count), .error_count(error_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st, en, er;
    logic [7:0]  typ;
    logic [31:0] grx;
    logic        sv;
    logic [31:0] sgm, sgd;
    logic        busy, rdy, mv;
    logic [31:0] mgd, gtm, gtd;
    logic [15:0] fc, ec;
    logic        to;
  } vec_t;

  vec_t tv[$];

  // Local lanes carry a half-swapped copy of the global lanes.
  function automatic logic [31:0] sw(input logic [31:0] x);
    return {x[15:0], x[31:16]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic st, en, er, input logic [7:0] typ, input logic [31:0] grx,
                     input logic sv, input logic [31:0] sgm, sgd,
                     input logic b, r, mv, input logic [31:0] mgd, gtm, gtd,
                     input logic [15:0] fc, ec, input logic to);
    vec_t v;
    v.st = st; v.en = en; v.er = er; v.typ = typ; v.grx = grx;
    v.sv = sv; v.sgm = sgm; v.sgd = sgd;
    v.busy = b; v.rdy = r; v.mv = mv; v.mgd = mgd; v.gtm = gtm; v.gtd = gtd;
    v.fc = fc; v.ec = ec; v.to = to;
    tv.push_back(v);
  endtask

  task automatic drive(input logic st, en, er, input logic [7:0] typ, input logic [31:0] grx,
                       input logic sv, input logic [31:0] sgm, sgd);
    rx_start = st; rx_end = en; rx_error = er; rx_type = typ;
    global_rx_data = grx; local_rx_data = sw(grx);
    s_valid = sv; s_global_mask = sgm; s_global_data = sgd;
    s_local_mask = sw(sgm); s_local_data = sw(sgd);
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 8'h00, 32'h0, 0, 32'h0, 32'h0);
    @(negedge clk);
    step(); step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_gtx_mask", global_tx_mask, 0);
    chk("rst_ltx_mask", local_tx_mask, 0);
    chk("rst_frame_count", 32'(frame_count), 0);
    chk("rst_error_count", 32'(error_count), 0);
    chk("rst_timeout", 32'(timeout), 0);

    // Watchdog: 100 cycles with no frame after reset release
    reset = 1'b1;
    repeat (99) step();
    chk("wdt_before_limit", 32'(timeout), 0);
    chk("idle_s_ready", 32'(s_ready), 1);
    step();
    chk("wdt_at_limit", 32'(timeout), 1);

    //   st en er typ    grx           sv sgm           sgd            busy rdy mv mgd           gtm           gtd           fc ec to
    // good frame with a shadow loaded beforehand
    add(0, 0, 0, 8'h00, 32'h0,        1, 32'h000000ff, 32'h000000a5,  0, 1, 0, 32'h0,        32'h0,        32'h0,        0, 0, 1);
    add(1, 0, 0, 8'h20, 32'h0,        0, 32'h0,        32'h0,         1, 1, 0, 32'h0,        32'h0,        32'h0,        0, 0, 1);
    add(0, 0, 0, 8'h00, 32'h0,        0, 32'h0,        32'h0,         1, 1, 0, 32'h0,        32'h0,        32'h0,        0, 0, 1);
    add(0, 1, 0, 8'h00, 32'h12345678, 0, 32'h0,        32'h0,         0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 1);
    add(0, 0, 0, 8'h00, 32'h12345678, 0, 32'h0,        32'h0,         0, 1, 1, 32'h12345678, 32'h000000ff, 32'h000000a5, 1, 0, 0);
    add(0, 0, 0, 8'h00, 32'h12345678, 0, 32'h0,        32'h0,         0, 1, 0, 32'h12345678, 32'h000000ff, 32'h000000a5, 1, 0, 0);
    // error frame
    add(1, 0, 0, 8'h20, 32'h0,        0, 32'h0,        32'h0,         1, 1, 0, 32'h12345678, 32'h000000ff, 32'h000000a5, 1, 0, 0);
    add(0, 0, 1, 8'h00, 32'h0,        0, 32'h0,        32'h0,         0, 1, 0, 32'h12345678, 32'h000000ff, 32'h000000a5, 1, 1, 0);
    // foreign frame type
    add(1, 0, 0, 8'h10, 32'h0,        0, 32'h0,        32'h0,         0, 1, 0, 32'h12345678, 32'h000000ff, 32'h000000a5, 1, 1, 0);
    add(0, 1, 0, 8'h00, 32'h99999999, 0, 32'h0,        32'h0,         0, 1, 0, 32'h12345678, 32'h000000ff, 32'h000000a5, 1, 1, 0);
    add(0, 0, 0, 8'h00, 32'h99999999, 0, 32'h0,        32'h0,         0, 1, 0, 32'h12345678, 32'h000000ff, 32'h000000a5, 1, 1, 0);
    // two shadow loads while active; last one wins at commit
    add(1, 0, 0, 8'h20, 32'h0,        0, 32'h0,        32'h0,         1, 1, 0, 32'h12345678, 32'h000000ff, 32'h000000a5, 1, 1, 0);
    add(0, 0, 0, 8'h00, 32'h0,        1, 32'h00000f0f, 32'h00001111,  1, 1, 0, 32'h12345678, 32'h000000ff, 32'h000000a5, 1, 1, 0);
    add(0, 0, 0, 8'h00, 32'h0,        1, 32'h0000f0f0, 32'h00002222,  1, 1, 0, 32'h12345678, 32'h000000ff, 32'h000000a5, 1, 1, 0);
    add(0, 1, 0, 8'h00, 32'hcafebabe, 0, 32'h0,        32'h0,         0, 0, 0, 32'h12345678, 32'h000000ff, 32'h000000a5, 1, 1, 0);
    add(0, 0, 0, 8'h00, 32'hcafebabe, 0, 32'h0,        32'h0,         0, 1, 1, 32'hcafebabe, 32'h0000f0f0, 32'h00002222, 2, 1, 0);
    add(0, 0, 0, 8'h00, 32'hcafebabe, 0, 32'h0,        32'h0,         0, 1, 0, 32'hcafebabe, 32'h0000f0f0, 32'h00002222, 2, 1, 0);
    // restart counts an error; start with end loses; load in COMMIT is refused
    add(1, 0, 0, 8'h20, 32'h0,        0, 32'h0,        32'h0,         1, 1, 0, 32'hcafebabe, 32'h0000f0f0, 32'h00002222, 2, 1, 0);
    add(1, 0, 0, 8'h20, 32'h0,        0, 32'h0,        32'h0,         1, 1, 0, 32'hcafebabe, 32'h0000f0f0, 32'h00002222, 2, 2, 0);
    add(1, 1, 0, 8'h20, 32'h00000042, 0, 32'h0,        32'h0,         0, 0, 0, 32'hcafebabe, 32'h0000f0f0, 32'h00002222, 2, 2, 0);
    add(0, 0, 0, 8'h00, 32'h00000042, 1, 32'h0000dead, 32'h0000beef,  0, 1, 1, 32'h00000042, 32'h0000f0f0, 32'h00002222, 3, 2, 0);
    add(0, 0, 0, 8'h00, 32'h00000042, 0, 32'h0,        32'h0,         0, 1, 0, 32'h00000042, 32'h0000f0f0, 32'h00002222, 3, 2, 0);
    add(1, 0, 0, 8'h20, 32'h0,        0, 32'h0,        32'h0,         1, 1, 0, 32'h00000042, 32'h0000f0f0, 32'h00002222, 3, 2, 0);
    add(0, 1, 0, 8'h00, 32'h00000001, 0, 32'h0,        32'h0,         0, 0, 0, 32'h00000042, 32'h0000f0f0, 32'h00002222, 3, 2, 0);
    add(0, 0, 0, 8'h00, 32'h00000001, 0, 32'h0,        32'h0,         0, 1, 1, 32'h00000001, 32'h0000f0f0, 32'h00002222, 4, 2, 0);

    foreach (tv[i]) begin
      drive(tv[i].st, tv[i].en, tv[i].er, tv[i].typ, tv[i].grx, tv[i].sv, tv[i].sgm, tv[i].sgd);
      step();
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tv[i].busy));
      chk($sformatf("v%0d_s_ready", i), 32'(s_ready), 32'(tv[i].rdy));
      chk($sformatf("v%0d_m_valid", i), 32'(m_valid), 32'(tv[i].mv));
      chk($sformatf("v%0d_m_global", i), m_global_data, tv[i].mgd);
      chk($sformatf("v%0d_m_local", i), m_local_data, sw(tv[i].mgd));
      chk($sformatf("v%0d_gtx_mask", i), global_tx_mask, tv[i].gtm);
      chk($sformatf("v%0d_gtx_data", i), global_tx_data, tv[i].gtd);
      chk($sformatf("v%0d_ltx_mask", i), local_tx_mask, sw(tv[i].gtm));
      chk($sformatf("v%0d_ltx_data", i), local_tx_data, sw(tv[i].gtd));
      chk($sformatf("v%0d_frame_count", i), 32'(frame_count), 32'(tv[i].fc));
      chk($sformatf("v%0d_error_count", i), 32'(error_count), 32'(tv[i].ec));
      chk($sformatf("v%0d_timeout", i), 32'(timeout), 32'(tv[i].to));
    end

    // Reset mid-frame
    drive(1, 0, 0, 8'h20, 32'h0, 0, 32'h0, 32'h0);
    step();
    chk("mid_busy", 32'(busy), 1);
    drive(0, 0, 0, 8'h00, 32'h0, 0, 32'h0, 32'h0);
    reset = 1'b0;
    step();
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_s_ready", 32'(s_ready), 0);
    chk("mrst_gtx_mask", global_tx_mask, 0);
    chk("mrst_gtx_data", global_tx_data, 0);
    chk("mrst_m_global", m_global_data, 0);
    chk("mrst_frame_count", 32'(frame_count), 0);
    chk("mrst_error_count", 32'(error_count), 0);
    reset = 1'b1;
    step();
    chk("post_s_ready", 32'(s_ready), 1);
    chk("post_busy", 32'(busy), 0);
    drive(0, 1, 0, 8'h00, 32'h55555555, 0, 32'h0, 32'h0);
    step();
    drive(0, 0, 0, 8'h00, 32'h55555555, 0, 32'h0, 32'h0);
    step();
    chk("abandoned_m_valid", 32'(m_valid), 0);
    chk("abandoned_frame_count", 32'(frame_count), 0);

    // Error counter saturation via continuous restarts
    drive(1, 0, 0, 8'h20, 32'h0, 0, 32'h0, 32'h0);
    step();
    repeat (65534) step();
    chk("sat_busy", 32'(busy), 1);
    chk("sat_below", 32'(error_count), 32'h0000fffe);
    step(); step();
    chk("sat_hold", 32'(error_count), 32'h0000ffff);
    chk("sat_wdt", 32'(timeout), 1);
    drive(0, 0, 1, 8'h00, 32'h0, 0, 32'h0, 32'h0);
    step();
    chk("sat_err_exit", 32'(error_count), 32'h0000ffff);
    chk("sat_err_idle", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jellyvl_etherneco_syncgpio_controller.md
# jellyvl_etherneco_syncgpio_controller

Sequencing controller for the EtherNeco sync-GPIO slave datapath. It watches frame events from the ring parser and freezes the tx mask/data image the datapath merges into a frame. On every good frame it commits received global/local GPIO data to the user side and swaps in a user-loaded shadow tx image. It also keeps frame/error statistics and a loss-of-sync watchdog.

## Interface
- GLOBAL_BYTES, 4, width of global GPIO image in bytes
- LOCAL_BYTES, 4, width of local (per-node) GPIO image in bytes
- FRAME_TYPE, 8'h20, rx_type value identifying a sync-GPIO frame
- TIMEOUT_CYCLES, 1000000, clk cycles without a commit before timeout is raised
- reset  input  1  synchronous, active-low reset
- clk  input  1  clock; all logic on rising edge
- rx_start / rx_end / rx_error  input  1 each  frame event pulses from parser
- rx_type  input  8  frame type, valid with rx_start
- global_rx_data  input  GLOBAL_BYTES*8  received global image, stable from rx_end until next rx_start
- local_rx_data  input  LOCAL_BYTES*8  received local image, same stability
- global_tx_mask / global_tx_data  output  GLOBAL_BYTES*8 each  active tx image to datapath
- local_tx_mask / local_tx_data  output  LOCAL_BYTES*8 each  active tx image to datapath
- s_global_mask / s_global_data / s_local_mask / s_local_data  input  matching widths  shadow tx image from user
- s_valid  input  1 / s_ready  output  1  shadow load handshake
- m_global_data / m_local_data  output  matching widths  last committed rx image
- m_valid  output  1  one-cycle pulse when m_* data updates
- busy  output  1  frame in progress
- timeout  output  1  sticky watchdog flag, cleared by next commit
- frame_count  output  16  good frames, wraps
- error_count  output  16  bad/aborted frames, saturates at 16'hffff

## Operation
- FSM states: IDLE, ACTIVE, COMMIT.
- IDLE: rx_start with rx_type==FRAME_TYPE -> ACTIVE. Other types ignored.
- ACTIVE: busy=1; active tx image frozen.
  - rx_end && !rx_error -> COMMIT.
  - rx_error, or rx_end with rx_error -> IDLE; error_count++.
  - rx_start again -> counted as error; stay ACTIVE (restart).
- COMMIT, exactly one cycle:
  - m_global/m_local <= rx inputs; frame_count++.
  - If shadow pending: active <= shadow; pending cleared.
  - Watchdog cleared; timeout cleared; -> IDLE.
- Shadow load: transfer when s_valid && s_ready; sets pending. Later loads before a commit overwrite the shadow (last wins).
- s_ready = 1 in IDLE and ACTIVE, 0 in COMMIT and during reset. A load never coincides with a swap.
- Watchdog: counts cycles since the last commit, saturating at TIMEOUT_CYCLES. At TIMEOUT_CYCLES, timeout=1. Active image is retained.
- Reset: all outputs 0 (tx masks 0, so the datapath forwards untouched). State IDLE, pending 0, counters 0. Reset mid-frame abandons the frame and does not count it.

## Timing
- rx_end sampled at edge N -> COMMIT during cycle N+1 -> m_valid high and new m_* data and tx image visible in cycle N+2.
- Error exit: error_count updates the cycle after rx_error is sampled.
- s_ready deasserts during the COMMIT cycle only (cycle N+1).
- Simultaneous rx_start and rx_end in ACTIVE: rx_end handling wins, then the rx_start is ignored (COMMIT does not accept starts).
- rx_start during COMMIT is ignored. The parser guarantees at least 2 cycles between rx_end and the next rx_start.
- Counter and watchdog widths: frame_count mod 2^16. Watchdog width is $clog2(TIMEOUT_CYCLES+1).

## Structure
- Package jellyvl_etherneco_syncgpio_pkg holds:
  - state enum (IDLE/ACTIVE/COMMIT)
  - default FRAME_TYPE constant
- Sub-module jellyvl_etherneco_syncgpio_watchdog:
  - inputs clear and enable; parameter TIMEOUT_CYCLES; output timeout.
  - Instantiated once.
- Rest is flat: FSM, shadow/active registers, counters.

## Test plan
- Good frame: load shadow global_mask=32'h000000ff, data=32'h000000a5. Send rx_start (type 8'h20), then rx_end with global_rx_data=32'h12345678. Expect m_valid at N+2, m_global_data=32'h12345678, global_tx_data=32'h000000a5, frame_count=1.
- Error frame: rx_start, then rx_error. Expect state IDLE, error_count=1, no m_valid, tx image unchanged.
- Shadow during frame: load a shadow while ACTIVE. Expect global_tx_* unchanged until commit, then swapped. A second load before commit wins.
- Foreign type: rx_start with rx_type=8'h10, then rx_end. Expect no busy, no m_valid, counters 0.
- Watchdog: TIMEOUT_CYCLES=100 with no frames. Expect timeout=1 at cycle 100 after reset. A good frame clears it at N+2.
- Reset mid-frame: assert reset low during ACTIVE. Expect all outputs 0 and s_ready=0 while low. After release, s_ready=1, state IDLE, counters 0.
